// File: rtl/sensor_sched_pkg.sv
// -----------------------------------------------------------------------------
// sensor_sched_pkg
// Shared definitions for the sensor measurement scheduler:
//   - FSM state encoding (2-bit) and the enum built on it
//   - sensor IDs (ultra = 0, DHT = 1)
//   - width of the optional fault statistics counters
//   - small integer helper used for counter sizing
// Optional feature macro (consumed by users of this package): SENSOR_SCHED_STATS_EN
// -----------------------------------------------------------------------------
package sensor_sched_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_GRANT = GRANT,
    S_WAIT  = WAIT,
    S_GAP   = GAP
  } sched_state_t;

  localparam logic SENS_ULTRA = 1'b0;
  localparam logic SENS_DHT   = 1'b1;

  localparam int STATS_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sensor_scheduler_if.sv
// -----------------------------------------------------------------------------
// sensor_scheduler_if
// Bundles the front-end and sensor-controller signals of sensor_scheduler.
//   master : the scheduler side (takes ticks/requests/dones, drives starts/status)
//   slave  : the environment side (front end + sensor controllers)
// Signals:
//   imSec, iEnable, iReq_Ultra, iReq_Dht, iDone_Ultra, iDone_Dht  (to scheduler)
//   oStart_Ultra, oStart_Dht, oBusy, oActive, oFault[1:0]          (from scheduler)
//   oFaultCnt_Ultra, oFaultCnt_Dht  only when SENSOR_SCHED_STATS_EN is defined
// -----------------------------------------------------------------------------
interface sensor_scheduler_if;
  import sensor_sched_pkg::*;

  logic       imSec;
  logic       iEnable;
  logic       iReq_Ultra;
  logic       iReq_Dht;
  logic       iDone_Ultra;
  logic       iDone_Dht;
  logic       oStart_Ultra;
  logic       oStart_Dht;
  logic       oBusy;
  logic       oActive;
  logic [1:0] oFault;
`ifdef SENSOR_SCHED_STATS_EN
  logic [STATS_W-1:0] oFaultCnt_Ultra;
  logic [STATS_W-1:0] oFaultCnt_Dht;
`endif

  modport master (
    input  imSec, iEnable, iReq_Ultra, iReq_Dht, iDone_Ultra, iDone_Dht,
    output oStart_Ultra, oStart_Dht, oBusy, oActive, oFault
`ifdef SENSOR_SCHED_STATS_EN
    , oFaultCnt_Ultra, oFaultCnt_Dht
`endif
  );

  modport slave (
    output imSec, iEnable, iReq_Ultra, iReq_Dht, iDone_Ultra, iDone_Dht,
    input  oStart_Ultra, oStart_Dht, oBusy, oActive, oFault
`ifdef SENSOR_SCHED_STATS_EN
    , oFaultCnt_Ultra, oFaultCnt_Dht
`endif
  );

endinterface

// File: rtl/sched_period_cnt.sv
// -----------------------------------------------------------------------------
// sched_period_cnt
// Millisecond interval counter. Advances on i_tick while i_en is high, holds
// otherwise. o_expire is a one-cycle pulse in the tick cycle that completes a
// full PERIOD_MS interval; the count wraps to 0 in that same cycle.
// Ports:
//   iClk, iRst_n : clock, asynchronous active-low reset
//   i_en         : count enable
//   i_tick       : 1 ms tick
//   o_expire     : interval expiry pulse (combinational from the count)
// -----------------------------------------------------------------------------
module sched_period_cnt
  import sensor_sched_pkg::*;
#(
  parameter int PERIOD_MS = 100
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic i_en,
  input  logic i_tick,
  output logic o_expire
);

  localparam int CW = $clog2(PERIOD_MS + 1);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_MS - 1);

  logic [CW-1:0] r_cnt;
  logic          w_step;

  assign w_step   = i_en & i_tick;
  assign o_expire = w_step & (r_cnt == LAST);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sensor_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_scheduler
// Time-shares one measurement slot between the SR04 controller (sensor 0) and
// the DHT11 controller (sensor 1). Periodic and manual requests are latched as
// pending bits, arbitrated round-robin, issued as one-cycle start pulses,
// supervised with a ms timeout and separated by a guard gap.
// Ports:
//   iClk, iRst_n : clock, asynchronous active-low reset
//   bus (master) : imSec, iEnable, iReq_*, iDone_*  ->  oStart_*, oBusy,
//                  oActive, oFault[1:0] (sticky per-sensor timeout flags)
// Optional feature macro SENSOR_SCHED_STATS_EN: adds saturating 8-bit timeout
// counters oFaultCnt_Ultra / oFaultCnt_Dht, cleared only by reset.
// -----------------------------------------------------------------------------
module sensor_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int ULTRA_PERIOD_MS  = 100,
  parameter int DHT_PERIOD_MS    = 2000,
  parameter int ULTRA_TIMEOUT_MS = 30,
  parameter int DHT_TIMEOUT_MS   = 50,
  parameter int GAP_MS           = 2
) (
  input  logic               iClk,
  input  logic               iRst_n,
  sensor_scheduler_if.master bus
);

  localparam int TW = $clog2(max_int(ULTRA_TIMEOUT_MS, DHT_TIMEOUT_MS) + 1);
  localparam logic [TW-1:0] ULTRA_LAST = TW'(ULTRA_TIMEOUT_MS - 1);
  localparam logic [TW-1:0] DHT_LAST   = TW'(DHT_TIMEOUT_MS - 1);
  // A zero gap still needs a 1-bit counter to keep the declarations legal.
  localparam int GW = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_MS > 0) ? GW'(GAP_MS - 1) : '0;

  sched_state_t  r_state, w_state_next;
  logic [1:0]    r_pend, w_pend_next;
  logic          r_rr, w_rr_next;
  logic          r_active, w_active_next;
  logic [1:0]    r_fault, w_fault_next;
  logic [TW-1:0] r_tcnt, w_tcnt_next;
  logic [GW-1:0] r_gcnt, w_gcnt_next;

  logic [1:0]    w_expire;
  logic [1:0]    w_set;
  logic          w_done;
  logic [TW-1:0] w_tlast;
  logic          w_timeout;
  logic          w_grant;

  // One interval counter per sensor; index matches the sensor ID.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_period
      localparam int P = (gi == 0) ? ULTRA_PERIOD_MS : DHT_PERIOD_MS;
      sched_period_cnt #(.PERIOD_MS(P)) u_period (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .i_en     (bus.iEnable),
        .i_tick   (bus.imSec),
        .o_expire (w_expire[gi])
      );
    end
  endgenerate

  // Manual and periodic requests for the same sensor merge into one bit.
  assign w_set   = w_expire | {bus.iReq_Dht, bus.iReq_Ultra};
  // Only the sensor in service can complete; a done from the other is ignored.
  assign w_done  = (r_active == SENS_DHT) ? bus.iDone_Dht : bus.iDone_Ultra;
  assign w_tlast = (r_active == SENS_DHT) ? DHT_LAST : ULTRA_LAST;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state  <= S_IDLE;
      r_pend   <= '0;
      r_rr     <= 1'b0;
      r_active <= 1'b0;
      r_fault  <= '0;
      r_tcnt   <= '0;
      r_gcnt   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pend   <= w_pend_next;
      r_rr     <= w_rr_next;
      r_active <= w_active_next;
      r_fault  <= w_fault_next;
      r_tcnt   <= w_tcnt_next;
      r_gcnt   <= w_gcnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pend_next   = r_pend;
    w_rr_next     = r_rr;
    w_active_next = r_active;
    w_fault_next  = r_fault;
    w_tcnt_next   = r_tcnt;
    w_gcnt_next   = r_gcnt;
    w_timeout     = 1'b0;
    w_grant       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          if (&r_pend) begin
            w_grant   = r_rr;
            w_rr_next = ~r_rr;
          end else begin
            w_grant = r_pend[SENS_DHT];
          end
          w_active_next          = w_grant;
          w_pend_next[w_grant]   = 1'b0;
          w_state_next           = S_GRANT;
        end
      end
      S_GRANT: begin
        w_tcnt_next  = '0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // Done is checked first so a coincident timeout tick loses.
        if (w_done) begin
          w_fault_next[r_active] = 1'b0;
          w_gcnt_next            = '0;
          w_state_next           = S_GAP;
        end else if (bus.imSec) begin
          if (r_tcnt == w_tlast) begin
            w_timeout    = 1'b1;
            w_gcnt_next  = '0;
            w_state_next = S_GAP;
          end else begin
            w_tcnt_next = r_tcnt + TW'(1);
          end
        end
      end
      S_GAP: begin
        if (GAP_MS == 0) begin
          w_state_next = S_IDLE;
        end else if (bus.imSec) begin
          if (r_gcnt == GAP_LAST) begin
            w_state_next = S_IDLE;
          end else begin
            w_gcnt_next = r_gcnt + GW'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_timeout) begin
      w_fault_next[r_active] = 1'b1;
    end
    // New requests win over the grant clear, so a request arriving for the
    // sensor being granted is kept and served after the gap.
    w_pend_next = w_pend_next | w_set;
  end

  assign bus.oStart_Ultra = (r_state == S_GRANT) && (r_active == SENS_ULTRA);
  assign bus.oStart_Dht   = (r_state == S_GRANT) && (r_active == SENS_DHT);
  assign bus.oBusy        = (r_state != S_IDLE);
  assign bus.oActive      = r_active;
  assign bus.oFault       = r_fault;

`ifdef SENSOR_SCHED_STATS_EN
  logic [STATS_W-1:0] r_fcnt_ultra;
  logic [STATS_W-1:0] r_fcnt_dht;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_fcnt_ultra <= '0;
      r_fcnt_dht   <= '0;
    end else if (w_timeout) begin
      if (r_active == SENS_ULTRA && r_fcnt_ultra != '1) begin
        r_fcnt_ultra <= r_fcnt_ultra + STATS_W'(1);
      end
      if (r_active == SENS_DHT && r_fcnt_dht != '1) begin
        r_fcnt_dht <= r_fcnt_dht + STATS_W'(1);
      end
    end
  end

  assign bus.oFaultCnt_Ultra = r_fcnt_ultra;
  assign bus.oFaultCnt_Dht   = r_fcnt_dht;
`endif

endmodule

// File: tb/tb_sensor_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sensor_scheduler
// Self-checking bench for sensor_scheduler. A behavioural reference model
// (pending flags, service record, ms counts) is stepped alongside the DUT and
// every cycle's outputs are compared; directed scenarios add explicit checks.
// Optional feature macro SENSOR_SCHED_STATS_EN enables the counter checks.
// -----------------------------------------------------------------------------
module tb_sensor_scheduler;

  localparam int UP = 4;
  localparam int DP = 10;
  localparam int UT = 3;
  localparam int DT = 5;
  localparam int GP = 1;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;

  sensor_scheduler_if bus ();

  sensor_scheduler #(
    .ULTRA_PERIOD_MS  (UP),
    .DHT_PERIOD_MS    (DP),
    .ULTRA_TIMEOUT_MS (UT),
    .DHT_TIMEOUT_MS   (DT),
    .GAP_MS           (GP)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int  per_cnt [2];
  bit  m_pend  [2];
  bit  m_rr;
  int  m_serving;      // sensor in service, -1 when none
  bit  m_start_due;    // the cycle right after a grant
  int  m_waited;       // ms elapsed while waiting for done
  bit  m_in_gap;
  int  m_gap_left;
  bit  m_active;
  bit [1:0] m_fault;
  int  m_tocnt [2];

  function automatic int period_of(input int s);
    return (s == 0) ? UP : DP;
  endfunction

  function automatic int timeout_of(input int s);
    return (s == 0) ? UT : DT;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      per_cnt[s] = 0;
      m_pend[s]  = 0;
      m_tocnt[s] = 0;
    end
    m_rr = 0; m_serving = -1; m_start_due = 0; m_waited = 0;
    m_in_gap = 0; m_gap_left = 0; m_active = 0; m_fault = 2'b00;
  endtask

  task automatic model_edge(input bit ms, input bit en, input bit ru, input bit rd,
                            input bit du, input bit dd);
    bit set [2];
    bit dn  [2];
    int g;
    set[0] = ru; set[1] = rd;
    dn[0]  = du; dn[1]  = dd;
    for (int s = 0; s < 2; s++) begin
      if (en && ms) begin
        if (per_cnt[s] == period_of(s) - 1) begin
          per_cnt[s] = 0;
          set[s] = 1;
        end else begin
          per_cnt[s]++;
        end
      end
    end
    if (m_serving < 0 && !m_in_gap) begin
      if (m_pend[0] || m_pend[1]) begin
        if (m_pend[0] && m_pend[1]) begin
          g = m_rr ? 1 : 0;
          m_rr = !m_rr;
        end else begin
          g = m_pend[1] ? 1 : 0;
        end
        m_pend[g] = 0; m_serving = g; m_active = (g == 1);
        m_start_due = 1; m_waited = 0;
      end
    end else if (m_start_due) begin
      m_start_due = 0;
      m_waited = 0;
    end else if (m_serving >= 0) begin
      if (dn[m_serving]) begin
        m_fault[m_serving] = 0;
        m_serving = -1; m_in_gap = 1; m_gap_left = GP;
      end else if (ms) begin
        m_waited++;
        if (m_waited == timeout_of(m_serving)) begin
          m_fault[m_serving] = 1;
          if (m_tocnt[m_serving] < 255) m_tocnt[m_serving]++;
          m_serving = -1; m_in_gap = 1; m_gap_left = GP;
        end
      end
    end else begin
      if (GP == 0) begin
        m_in_gap = 0;
      end else if (ms) begin
        m_gap_left--;
        if (m_gap_left == 0) m_in_gap = 0;
      end
    end
    for (int s = 0; s < 2; s++) if (set[s]) m_pend[s] = 1;
  endtask

  function automatic logic [5:0] model_vec();
    return {m_start_due && m_serving == 0, m_start_due && m_serving == 1,
            (m_serving >= 0) || m_in_gap, m_active, m_fault};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {bus.oStart_Ultra, bus.oStart_Dht, bus.oBusy, bus.oActive, bus.oFault};
  endfunction

  function automatic bit model_idle();
    return (m_serving < 0) && !m_in_gap && !m_pend[0] && !m_pend[1];
  endfunction

  // One clock: drive inputs, advance DUT and model, compare just after the edge.
  task automatic step(input bit ms, input bit en, input bit ru, input bit rd,
                      input bit du, input bit dd);
    bus.imSec = ms; bus.iEnable = en; bus.iReq_Ultra = ru; bus.iReq_Dht = rd;
    bus.iDone_Ultra = du; bus.iDone_Dht = dd;
    @(posedge iClk);
    if (iRst_n) model_edge(ms, en, ru, rd, du, dd);
    else model_reset();
    #1;
    check("outs", 32'(dut_vec()), 32'(model_vec()));
    if (bus.oStart_Ultra || bus.oStart_Dht) n_start++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!model_idle() && k < 200) begin
      step(1, 0, 0, 0, m_serving == 0 && !m_start_due, m_serving == 1 && !m_start_due);
      k++;
    end
    if (!model_idle()) check("drain_bound", 32'(k), 32'(0));
  endtask

  bit en_r;
  bit r_ms, r_ru, r_rd, r_du, r_dd;

  initial begin
    bus.imSec = 0; bus.iEnable = 0; bus.iReq_Ultra = 0; bus.iReq_Dht = 0;
    bus.iDone_Ultra = 0; bus.iDone_Dht = 0;
    model_reset();

    // Reset state
    repeat (3) step(0, 0, 1, 1, 0, 0);
    check("reset_outs", 32'(dut_vec()), 32'(0));
    iRst_n = 1'b1;

    // Periodic service: done 2 ms (ultra) / 3 ms (DHT) after start
    for (int c = 0; c < 300; c++) begin
      step(c % 10 == 9, 1, 0, 0,
           m_serving == 0 && !m_start_due && m_waited == 2,
           m_serving == 1 && !m_start_due && m_waited == 3);
    end
    check("periodic_fault", 32'(bus.oFault), 32'(0));
    drain();

    // Simultaneous pending requests
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("simul_first_ultra", 32'(bus.oStart_Ultra), 32'(1));
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("simul_second_dht", 32'(bus.oStart_Dht), 32'(1));
    drain();
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    drain();

    // Ultra timeout, then recovery
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("timeout_fault", 32'(bus.oFault), 32'(2'b01));
    check("timeout_gap_busy", 32'(bus.oBusy), 32'(1));
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check("fault_clear", 32'(bus.oFault), 32'(2'b00));
    drain();

    // DHT done coinciding with its final timeout tick
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    check("done_wins_fault", 32'(bus.oFault[1]), 32'(0));
    check("done_wins_busy", 32'(bus.oBusy), 32'(1));
    drain();

    // Randomized traffic
    en_r = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) en_r = ($urandom_range(0, 3) != 0);
      r_ms = ($urandom_range(0, 4) == 0);
      r_ru = ($urandom_range(0, 39) == 0);
      r_rd = ($urandom_range(0, 39) == 0);
      r_du = (m_serving == 0 && $urandom_range(0, 7) == 0) || ($urandom_range(0, 29) == 0);
      r_dd = (m_serving == 1 && $urandom_range(0, 7) == 0) || ($urandom_range(0, 29) == 0);
      step(r_ms, en_r, r_ru, r_rd, r_du, r_dd);
    end
    drain();

    // Asynchronous reset in the middle of WAIT
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #2;
    iRst_n = 1'b0;
    #1;
    check("async_rst_outs", 32'(dut_vec()), 32'(0));
    model_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0);
    iRst_n = 1'b1;
    n_start = 0;
    repeat (20) step(1, 0, 0, 0, 0, 0);
    check("post_rst_starts", 32'(n_start), 32'(0));

    // Repeated ultra timeouts (saturates the optional counter)
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      repeat (4) step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
    end
`ifdef SENSOR_SCHED_STATS_EN
    check("fcnt_ultra", 32'(bus.oFaultCnt_Ultra), 32'(255));
    check("fcnt_dht", 32'(bus.oFaultCnt_Dht), 32'(0));
    check("fcnt_ultra_model", 32'(bus.oFaultCnt_Ultra), 32'(m_tocnt[0]));
`endif
    check("stress_fault", 32'(bus.oFault), 32'(2'b01));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
